// File: rtl/mult_pkg.sv
// Shared types and constants for the MULT/MULTU shift-add sequencer.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  localparam int MULT_WIDTH = 32;

endpackage

// File: rtl/mult_sequencer.sv
// Multi-cycle shift-add multiplier with architectural HI/LO registers.
// Signed operands are reduced to magnitudes, multiplied unsigned, then negated if needed.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inpStart,
  input  logic             inpSigned,
  input  logic [WIDTH-1:0] inpMultA,
  input  logic [WIDTH-1:0] inpMultB,
  input  logic             inpHiWe,
  input  logic             inpLoWe,
  input  logic [WIDTH-1:0] inpWrData,
  output logic             outBusy,
  output logic             outDone,
  output logic [WIDTH-1:0] outHi,
  output logic [WIDTH-1:0] outLo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_CNT  = CW'(1);

  mult_state_t        state_q, state_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] fix_s;

  // Magnitude of a two's-complement value; the most negative input maps to 2^(W-1).
  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return ~v + ONE_W;
    end else begin
      return v;
    end
  endfunction

  // Next-state, datapath step and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
            (mag_b_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
    fix_s = neg_q ? (~acc_q + ONE_2W) : acc_q;

    case (state_q)
      IDLE: begin
        if (inpHiWe) begin
          hi_d = inpWrData;
        end else begin
          hi_d = hi_q;
        end
        if (inpLoWe) begin
          lo_d = inpWrData;
        end else begin
          lo_d = lo_q;
        end
        if (inpStart) begin
          mag_a_d = inpSigned ? abs_f(inpMultA) : inpMultA;
          mag_b_d = inpSigned ? abs_f(inpMultB) : inpMultB;
          neg_d   = inpSigned & (inpMultA[WIDTH-1] ^ inpMultB[WIDTH-1]);
          acc_d   = {(2*WIDTH){1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The add carry becomes the new MSB as {carry,acc} shifts right.
        acc_d   = {sum_s, acc_q[WIDTH-1:1]};
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + ONE_CNT;
        if (cnt_q == LAST_CNT) begin
          state_d = FIXUP;
        end else begin
          state_d = RUN;
        end
      end
      FIXUP: begin
        acc_d   = fix_s;
        hi_d    = fix_s[2*WIDTH-1:WIDTH];
        lo_d    = fix_s[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == FIXUP);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_a_q <= {WIDTH{1'b0}};
      mag_b_q <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      acc_q   <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CW{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign outBusy = busy_q;
  assign outDone = done_q;
  assign outHi   = hi_q;
  assign outLo   = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed corners, random operands, handshake and reset.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inpStart = 1'b0;
  logic        inpSigned = 1'b0;
  logic [31:0] inpMultA = 32'd0;
  logic [31:0] inpMultB = 32'd0;
  logic        inpHiWe = 1'b0;
  logic        inpLoWe = 1'b0;
  logic [31:0] inpWrData = 32'd0;
  logic        outBusy;
  logic        outDone;
  logic [31:0] outHi;
  logic [31:0] outLo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inpStart  (inpStart),
    .inpSigned (inpSigned),
    .inpMultA  (inpMultA),
    .inpMultB  (inpMultB),
    .inpHiWe   (inpHiWe),
    .inpLoWe   (inpLoWe),
    .inpWrData (inpWrData),
    .outBusy   (outBusy),
    .outDone   (outDone),
    .outHi     (outHi),
    .outLo     (outLo)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Presents a start for one edge; returns in cycle 1 of the operation.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    inpMultA  = a;
    inpMultB  = b;
    inpSigned = sgn;
    inpStart  = 1'b1;
    tick();
    inpStart  = 1'b0;
  endtask

  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (outDone !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (outBusy !== 1'b0 || outDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b done=%b expected 0 0", outBusy, outDone);
    end
    checks++;
    if (outHi !== 32'd0 || outLo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h_%h expected 0_0", outHi, outLo);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    start_op(32'd2, 32'd4, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      checks++;
      if (outBusy !== (k <= 33) || outDone !== (k == 34)) begin
        errors++;
        $display("FAIL latency_c%0d: got busy=%b done=%b expected busy=%b done=%b",
                 k, outBusy, outDone, (k <= 33), (k == 34));
      end
      if (k < 34) tick();
    end
    checks++;
    if ({outHi, outLo} !== 64'd8) begin
      errors++;
      $display("FAIL lat_result: got %h_%h expected 00000000_00000008", outHi, outLo);
    end
    tick();
    checks++;
    if (outDone !== 1'b0 || outBusy !== 1'b0 || outLo !== 32'd8) begin
      errors++;
      $display("FAIL after_done: got done=%b busy=%b lo=%h expected 0 0 00000008",
               outDone, outBusy, outLo);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[7];
    int   lat;
    vecs[0] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{32'hFFFFFFFE, 32'hFFFFFFFC, 1'b1, 32'h00000000, 32'h00000008};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_done(1, lat);
      checks++;
      if (lat !== 34) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d expected 34", i, lat);
      end
      checks++;
      if (outHi !== vecs[i].hi || outLo !== vecs[i].lo) begin
        errors++;
        $display("FAIL dir%0d_product: got %h_%h expected %h_%h",
                 i, outHi, outLo, vecs[i].hi, vecs[i].lo);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        s;
    logic [63:0] exp_p;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 6 == 5) a = 32'h80000000;
      if (i % 8 == 7) b = 32'd0;
      exp_p = ref_product(a, b, s);
      start_op(a, b, s);
      wait_done(1, lat);
      checks++;
      if (lat !== 34 || {outHi, outLo} !== exp_p) begin
        errors++;
        $display("FAIL rand%0d: a=%h b=%h s=%b got %h_%h lat=%0d expected %h lat=34",
                 i, a, b, s, outHi, outLo, lat, exp_p);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi_before;
    int          lat;
    hi_before = outHi;
    start_op(32'd5, 32'd7, 1'b0);
    repeat (9) tick();
    inpMultA  = 32'd9;
    inpMultB  = 32'd9;
    inpStart  = 1'b1;
    inpHiWe   = 1'b1;
    inpWrData = 32'hDEADBEEF;
    tick();
    inpStart  = 1'b0;
    inpHiWe   = 1'b0;
    checks++;
    if (outHi !== hi_before || outBusy !== 1'b1) begin
      errors++;
      $display("FAIL busy_write: got hi=%h busy=%b expected hi=%h busy=1", outHi, outBusy, hi_before);
    end
    wait_done(11, lat);
    checks++;
    if (lat !== 34 || outHi !== 32'd0 || outLo !== 32'd35) begin
      errors++;
      $display("FAIL ignored_start: got %h_%h lat=%0d expected 00000000_00000023 lat=34",
               outHi, outLo, lat);
    end
    inpStart  = 1'b1;
    inpHiWe   = 1'b1;
    inpWrData = 32'h12345678;
    tick();
    inpStart  = 1'b0;
    inpHiWe   = 1'b0;
    checks++;
    if (outBusy !== 1'b0 || outHi !== 32'd0) begin
      errors++;
      $display("FAIL done_ignore: got busy=%b hi=%h expected busy=0 hi=00000000", outBusy, outHi);
    end
    inpHiWe   = 1'b1;
    inpWrData = 32'hDEADBEEF;
    tick();
    inpHiWe   = 1'b0;
    checks++;
    if (outHi !== 32'hDEADBEEF || outLo !== 32'd35) begin
      errors++;
      $display("FAIL mthi: got %h_%h expected deadbeef_00000023", outHi, outLo);
    end
    inpHiWe   = 1'b1;
    inpLoWe   = 1'b1;
    inpWrData = 32'h0BADF00D;
    tick();
    inpHiWe   = 1'b0;
    inpLoWe   = 1'b0;
    checks++;
    if (outHi !== 32'h0BADF00D || outLo !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL mthi_mtlo: got %h_%h expected 0badf00d_0badf00d", outHi, outLo);
    end
    inpLoWe   = 1'b1;
    inpWrData = 32'hCAFEF00D;
    start_op(32'd3, 32'd5, 1'b0);
    inpLoWe   = 1'b0;
    checks++;
    if (outLo !== 32'hCAFEF00D || outBusy !== 1'b1) begin
      errors++;
      $display("FAIL start_write: got lo=%h busy=%b expected lo=cafef00d busy=1", outLo, outBusy);
    end
    wait_done(1, lat);
    checks++;
    if (lat !== 34 || outHi !== 32'd0 || outLo !== 32'd15) begin
      errors++;
      $display("FAIL overwrite: got %h_%h lat=%0d expected 00000000_0000000f lat=34",
               outHi, outLo, lat);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    int lat;
    inpHiWe   = 1'b1;
    inpWrData = 32'hA5A5A5A5;
    tick();
    inpHiWe   = 1'b0;
    start_op(32'd6, 32'd6, 1'b1);
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (outBusy !== 1'b0 || outDone !== 1'b0 || outHi !== 32'd0 || outLo !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b %h_%h expected 0 0 0_0",
               outBusy, outDone, outHi, outLo);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (outDone === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL no_done_after_abort: got %0d pulses expected 0", done_seen);
    end
    start_op(32'd3, 32'd3, 1'b1);
    wait_done(1, lat);
    checks++;
    if (lat !== 34 || outHi !== 32'd0 || outLo !== 32'd9) begin
      errors++;
      $display("FAIL post_reset_mult: got %h_%h lat=%0d expected 00000000_00000009 lat=34",
               outHi, outLo, lat);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
